perceptron_seq: RTL and testbench



---
 rtl/perceptron_seq_if.sv | 39 +++
 rtl/perceptron_seq.sv | 132 +++++++++++++
 tb/tb_perceptron_seq.sv | 208 ++++++++++++++++++++
 3 files changed

// File: rtl/perceptron_seq_if.sv
// Bundles the config write port and the input/output streams of perceptron_seq.
// master drives config, inputs and out_ready; slave is the neuron itself.
interface perceptron_seq_if #(
  parameter int N_INPUTS = 4,
  parameter int DATA_W   = 10,
  parameter int ACC_W    = 24
);
  localparam int ADDR_W = $clog2(N_INPUTS + 1);

  logic                       cfg_we;
  logic [ADDR_W-1:0]          cfg_addr;
  logic signed [DATA_W-1:0]   cfg_wdata;
  logic                       in_valid;
  logic                       in_ready;
  logic [N_INPUTS*DATA_W-1:0] in_x;
  logic                       in_train;
  logic                       in_target;
  logic                       out_valid;
  logic                       out_ready;
  logic                       out_y;
  logic signed [ACC_W-1:0]    out_sum;
  logic                       out_updated;

  modport master (
    output cfg_we, cfg_addr, cfg_wdata,
    output in_valid, in_x, in_train, in_target,
    input  in_ready,
    output out_ready,
    input  out_valid, out_y, out_sum, out_updated
  );

  modport slave (
    input  cfg_we, cfg_addr, cfg_wdata,
    input  in_valid, in_x, in_train, in_target,
    output in_ready,
    input  out_ready,
    output out_valid, out_y, out_sum, out_updated
  );
endinterface

// File: rtl/perceptron_seq.sv
// Sequential perceptron: one MAC per cycle over stored weights and bias, with an
// optional in-block perceptron learning step applied one register per cycle.
module perceptron_seq #(
  parameter int N_INPUTS = 4,
  parameter int DATA_W   = 10,
  parameter int ACC_W    = 24,
  parameter int LR_SHIFT = 0
) (
  input logic             clk,
  input logic             rst_n,
  perceptron_seq_if.slave bus
);
  localparam int IDX_W  = $clog2(N_INPUTS + 1);
  localparam int PROD_W = 2 * DATA_W;
  localparam logic [IDX_W-1:0] LAST = IDX_W'(N_INPUTS);
  localparam logic signed [DATA_W-1:0] W_MAX = {1'b0, {(DATA_W-1){1'b1}}};
  localparam logic signed [DATA_W-1:0] W_MIN = {1'b1, {(DATA_W-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, MAC, UPD, OUT} state_t;
  state_t state, state_next;

  // Slot N_INPUTS holds the bias and pairs with a constant input of 1, so the
  // bias term and its learning delta fall out of the same per-slot datapath.
  logic signed [DATA_W-1:0] wreg [N_INPUTS+1];
  logic signed [DATA_W-1:0] xreg [N_INPUTS+1];

  logic [IDX_W-1:0]         idx;
  logic signed [ACC_W-1:0]  acc, acc_next;
  logic signed [PROD_W-1:0] prod;
  logic signed [DATA_W-1:0] delta, upd_val;
  logic [DATA_W:0]          upd_sum;
  logic                     train_q, target_q;
  logic                     last_slot, sum_pos, mispredict, take_in;

  always_comb begin
    last_slot  = (idx == LAST);
    prod       = PROD_W'(wreg[idx]) * PROD_W'(xreg[idx]);
    acc_next   = acc + {{(ACC_W-PROD_W){prod[PROD_W-1]}}, prod};
    sum_pos    = !acc_next[ACC_W-1] && (acc_next != '0);
    mispredict = train_q && (sum_pos != target_q);

    delta   = xreg[idx] >>> LR_SHIFT;
    upd_sum = target_q ? ({wreg[idx][DATA_W-1], wreg[idx]} + {delta[DATA_W-1], delta})
                       : ({wreg[idx][DATA_W-1], wreg[idx]} - {delta[DATA_W-1], delta});
    // One guard bit is enough: differing top bits mean the step left the range.
    if (upd_sum[DATA_W] != upd_sum[DATA_W-1])
      upd_val = upd_sum[DATA_W] ? W_MIN : W_MAX;
    else
      upd_val = upd_sum[DATA_W-1:0];
  end

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    // NOTE: every output gets a default before the case, so no path can leave one
    // unassigned and infer a latch.
    state_next    = state;
    bus.in_ready  = 1'b0;
    bus.out_valid = 1'b0;
    take_in       = 1'b0;
    case (state)
      IDLE: begin
        bus.in_ready = rst_n && !bus.cfg_we;
        take_in      = rst_n && !bus.cfg_we && bus.in_valid;
        if (take_in) state_next = MAC;
      end
      MAC: if (last_slot) state_next = mispredict ? UPD : OUT;
      UPD: if (last_slot) state_next = OUT;
      OUT: begin
        bus.out_valid = 1'b1;
        if (bus.out_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      // NOTE: the weight file is reset explicitly because a reset neuron must
      // restart untrained; it is small enough to live in flops, not a RAM macro.
      for (int i = 0; i <= N_INPUTS; i++) begin
        wreg[i] <= '0;
        xreg[i] <= '0;
      end
      idx             <= '0;
      acc             <= '0;
      train_q         <= 1'b0;
      target_q        <= 1'b0;
      bus.out_y       <= 1'b0;
      bus.out_sum     <= '0;
      bus.out_updated <= 1'b0;
    end else begin
      // NOTE: state is updated with <= only, so every flop samples pre-edge values
      // regardless of statement order.
      case (state)
        IDLE: begin
          if (bus.cfg_we) begin
            if (bus.cfg_addr <= LAST) wreg[bus.cfg_addr] <= bus.cfg_wdata;
          end else if (take_in) begin
            for (int i = 0; i < N_INPUTS; i++)
              xreg[i] <= bus.in_x[i*DATA_W +: DATA_W];
            xreg[N_INPUTS]  <= DATA_W'(1);
            train_q         <= bus.in_train;
            target_q        <= bus.in_target;
            acc             <= '0;
            idx             <= '0;
            bus.out_updated <= 1'b0;
          end
        end
        MAC: begin
          acc <= acc_next;
          if (last_slot) begin
            bus.out_sum     <= acc_next;
            bus.out_y       <= sum_pos;
            bus.out_updated <= mispredict;
            idx             <= '0;
          end else begin
            idx <= idx + 1'b1;
          end
        end
        UPD: begin
          wreg[idx] <= upd_val;
          idx       <= idx + 1'b1;
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_perceptron_seq.sv
// Randomised and directed bench for perceptron_seq against an arithmetic model
// of the neuron (sum, step, learning rule with saturation, latency).
module tb_perceptron_seq;
  localparam int N    = 2;
  localparam int DW   = 10;
  localparam int AW   = 24;
  localparam int LR   = 0;
  localparam int ADW  = $clog2(N + 1);
  localparam int WMAX = 2 ** (DW - 1) - 1;
  localparam int WMIN = -(2 ** (DW - 1));

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  perceptron_seq_if #(.N_INPUTS(N), .DATA_W(DW), .ACC_W(AW)) io ();

  perceptron_seq #(.N_INPUTS(N), .DATA_W(DW), .ACC_W(AW), .LR_SHIFT(LR)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (io)
  );

  int n_checks = 0;
  int n_pass   = 0;
  int mw [N+1];   // model weights, index N is the bias
  int tx_x [N];

  task automatic check(input string tag, input longint got, input longint exp);
    n_checks++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
  endtask

  function automatic int sat(input int v);
    if (v > WMAX) return WMAX;
    if (v < WMIN) return WMIN;
    return v;
  endfunction

  function automatic longint model_sum();
    longint s = longint'(mw[N]);
    for (int i = 0; i < N; i++) s += longint'(mw[i]) * longint'(tx_x[i]);
    return s;
  endfunction

  task automatic drive_x();
    for (int i = 0; i < N; i++) io.in_x[i*DW +: DW] = DW'(tx_x[i]);
  endtask

  task automatic cfg_write(input int addr, input int data);
    io.cfg_we    = 1'b1;
    io.cfg_addr  = ADW'(addr);
    io.cfg_wdata = DW'(data);
    @(negedge clk);
    io.cfg_we = 1'b0;
    if (addr <= N) mw[addr] = data;
  endtask

  task automatic run_txn(input string tag, input bit train, input bit target,
                         input int hold, input bit cfg_mid);
    longint exp_sum;
    bit     exp_y, exp_upd;
    int     exp_lat, k, d;
    exp_sum = model_sum();
    exp_y   = exp_sum > 0;
    exp_upd = train && (exp_y != target);
    exp_lat = exp_upd ? 2 * N + 2 : N + 1;

    drive_x();
    io.in_train  = train;
    io.in_target = target;
    io.in_valid  = 1'b1;
    #1 check({tag, " in_ready idle"}, io.in_ready, 1);
    @(negedge clk);
    io.in_valid = 1'b0;
    k = 0;
    if (cfg_mid) begin
      io.cfg_we    = 1'b1;
      io.cfg_addr  = '0;
      io.cfg_wdata = DW'(mw[0] + 37);
      @(negedge clk);
      io.cfg_we = 1'b0;
      k = 1;
    end
    while (!io.out_valid && k < 200) begin
      @(negedge clk);
      k++;
    end
    check({tag, " latency"}, k, exp_lat);
    for (int h = 0; h < hold; h++) begin
      check({tag, " hold out_valid"}, io.out_valid, 1);
      check({tag, " hold out_sum"}, io.out_sum, exp_sum);
      check({tag, " hold out_y"}, io.out_y, exp_y);
      check({tag, " hold in_ready"}, io.in_ready, 0);
      @(negedge clk);
    end
    check({tag, " out_valid"}, io.out_valid, 1);
    check({tag, " out_sum"}, io.out_sum, exp_sum);
    check({tag, " out_y"}, io.out_y, exp_y);
    check({tag, " out_updated"}, io.out_updated, exp_upd);
    io.out_ready = 1'b1;
    @(negedge clk);
    io.out_ready = 1'b0;
    check({tag, " out_valid drop"}, io.out_valid, 0);
    check({tag, " in_ready after"}, io.in_ready, 1);

    if (exp_upd) begin
      for (int i = 0; i < N; i++) begin
        d = tx_x[i] >>> LR;
        mw[i] = sat(target ? mw[i] + d : mw[i] - d);
      end
      d = 1 >>> LR;
      mw[N] = sat(target ? mw[N] + d : mw[N] - d);
    end
  endtask

  task automatic set_weights(input int w0, input int w1, input int b);
    cfg_write(0, w0);
    cfg_write(1, w1);
    cfg_write(N, b);
  endtask

  initial begin
    bit seen;
    for (int i = 0; i <= N; i++) mw[i] = 0;
    io.cfg_we = 1'b0; io.cfg_addr = '0; io.cfg_wdata = '0;
    io.in_valid = 1'b0; io.in_x = '0; io.in_train = 1'b0; io.in_target = 1'b0;
    io.out_ready = 1'b0;

    repeat (3) @(negedge clk);
    check("reset in_ready", io.in_ready, 0);
    check("reset out_valid", io.out_valid, 0);
    check("reset out_y", io.out_y, 0);
    check("reset out_sum", io.out_sum, 0);
    check("reset out_updated", io.out_updated, 0);
    rst_n = 1'b1;
    #1 check("release in_ready", io.in_ready, 1);
    @(negedge clk);

    set_weights(1, 1, -1);
    tx_x = '{1, 1}; run_txn("infer11", 0, 0, 0, 0);
    tx_x = '{1, 0}; run_txn("infer10", 0, 0, 0, 0);

    set_weights(0, 0, 0);
    tx_x = '{1, 1}; run_txn("train", 1, 1, 0, 0);
    run_txn("train readback", 0, 0, 0, 0);

    set_weights(WMAX, 0, WMIN);
    tx_x = '{1, 0}; run_txn("sat pos", 1, 1, 0, 0);
    run_txn("sat pos readback", 0, 0, 0, 0);

    set_weights(WMIN, 10, WMAX);
    tx_x = '{1, 1}; run_txn("sat neg", 1, 0, 0, 0);
    tx_x = '{1, 0}; run_txn("sat neg readback", 0, 0, 0, 0);

    set_weights(3, -2, 1);
    tx_x = '{7, 4}; run_txn("backpressure", 0, 0, 5, 0);

    tx_x = '{1, 1};
    drive_x();
    io.in_train  = 1'b0;
    io.in_valid  = 1'b1;
    io.cfg_we    = 1'b1;
    io.cfg_addr  = '0;
    io.cfg_wdata = DW'(9);
    #1 check("cfg+in in_ready", io.in_ready, 0);
    @(negedge clk);
    io.cfg_we = 1'b0;
    mw[0] = 9;
    run_txn("cfg then in", 0, 0, 0, 0);

    tx_x = '{2, 3}; run_txn("cfg during mac", 0, 0, 0, 1);
    run_txn("cfg mac readback", 0, 0, 0, 0);

    cfg_write(3, 100);
    run_txn("bad addr readback", 0, 0, 0, 0);

    tx_x = '{3, 4};
    drive_x();
    io.in_valid = 1'b1;
    @(negedge clk);
    io.in_valid = 1'b0;
    rst_n = 1'b0;
    #1 check("mid reset in_ready", io.in_ready, 0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i <= N; i++) mw[i] = 0;
    seen = 1'b0;
    repeat (10) begin
      @(negedge clk);
      seen |= io.out_valid;
    end
    check("mid reset no out_valid", seen, 0);
    tx_x = '{5, 5}; run_txn("post reset", 0, 0, 0, 0);

    for (int t = 0; t < 60; t++) begin
      if ($urandom_range(2) == 0)
        cfg_write(int'($urandom_range(3)), int'($urandom_range(1023)) - 512);
      for (int i = 0; i < N; i++) tx_x[i] = int'($urandom_range(1023)) - 512;
      run_txn("random", 1'($urandom_range(1)), 1'($urandom_range(1)),
              int'($urandom_range(2)), $urandom_range(3) == 0);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
